// File: rtl/pc_pkg.sv
// Shared encodings and defaults for the fetch-stage program counter.
package pc_pkg;
  typedef enum logic [1:0] {
    JMP_SEQ  = 2'b00,
    JMP_ABS  = 2'b01,
    JMP_FWD  = 2'b10,
    JMP_ABS2 = 2'b11
  } jump_e;

  localparam int          DEF_INC          = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push onto a full stack silently overwrites the oldest entry.
module return_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] cnt;

  assign ptr_dec = ptr - PTR_W'(1);
  assign top     = mem[ptr_dec];
  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && pop) begin
      // Indirect call: replace the top in place; on an empty stack it acts as a plain push.
      if (empty) begin
        ptr <= ptr + PTR_W'(1);
        cnt <= CNT_W'(1);
      end
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_dec;
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear && push)
      mem[(pop && !empty) ? ptr_dec : ptr] <= push_data;
  end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC register with prioritised next-PC selection, stall hold, flush redirect and RAS.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               INC          = DEF_INC,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       jump,
  input  logic [WIDTH-1:0] jump_add,
  input  logic [WIDTH-1:0] jump_forward_add,
  input  logic             call,
  input  logic             ret,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_add,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_top;
  logic             adv;

  assign pc_inc = pc + WIDTH'(INC);
  assign adv    = !flush && !stall;

  always_comb begin
    pc_4 = pc_inc;
    if (flush)
      pc_4 = flush_add;
    else if (ret)
      pc_4 = ras_empty ? jump_add : ras_top;
    else begin
      unique case (jump_e'(jump))
        JMP_ABS, JMP_ABS2: pc_4 = jump_add;
        JMP_FWD:           pc_4 = jump_forward_add;
        default:           pc_4 = pc_inc;
      endcase
    end
  end

  return_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (adv && call),
    .pop       (adv && ret),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      ras_underflow <= 1'b0;
    end else if (flush) begin
      pc            <= flush_add;
      ras_underflow <= 1'b0;
    end else if (stall) begin
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_4;
      ras_underflow <= ret && ras_empty;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters (WIDTH=32, INC=4, RAS_DEPTH=4).
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, call, ret, flush;
  logic [1:0]  jump;
  logic [31:0] jump_add, jump_forward_add, flush_add;
  logic [31:0] pc, pc_4;
  logic        ras_empty, ras_full, ras_underflow;
  int          n_checks = 0;
  int          n_fail   = 0;

  pc_unit #(.WIDTH(32), .INC(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jump_add(jump_add),
    .jump_forward_add(jump_forward_add), .call(call), .ret(ret), .flush(flush),
    .flush_add(flush_add), .pc(pc), .pc_4(pc_4), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; call = 0; ret = 0; flush = 0; jump = 2'b00;
    jump_add = '0; jump_forward_add = '0; flush_add = '0;
  endtask

  task automatic do_flush(input logic [31:0] a);
    idle_inputs(); flush = 1; flush_add = a; step(); flush = 0;
  endtask

  task automatic do_call(input logic [31:0] tgt);
    idle_inputs(); call = 1; jump = 2'b01; jump_add = tgt; step(); call = 0; jump = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1; step(); step(); reset = 0;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    n_checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b%b%b exp=100", ras_empty, ras_full, ras_underflow); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++; if (pc !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'(i * 4)); end
    end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL seq_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_branch_stall_flush();
    idle_inputs(); jump = 2'b11; jump_add = 32'h100; step();
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL jump11_pc got=%h exp=%h", pc, 32'h100); end
    jump = 2'b10; jump_forward_add = 32'h200; jump_add = 32'h999; #1;
    n_checks++; if (pc_4 !== 32'h200) begin n_fail++; $display("FAIL fwd_pc4 got=%h exp=%h", pc_4, 32'h200); end
    step(); jump = 2'b00;
    n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL fwd_pc got=%h exp=%h", pc, 32'h200); end
    stall = 1; step(); step();
    n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL stall_pc got=%h exp=%h", pc, 32'h200); end
    flush = 1; flush_add = 32'h80; #1;
    n_checks++; if (pc_4 !== 32'h80) begin n_fail++; $display("FAIL flush_pc4 got=%h exp=%h", pc_4, 32'h80); end
    step(); idle_inputs();
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL flush_stall_pc got=%h exp=%h", pc, 32'h80); end
  endtask

  task automatic test_call_ret();
    do_flush(32'h10);
    do_call(32'h400);
    n_checks++; if (pc !== 32'h400 || ras_empty !== 1'b0) begin
      n_fail++; $display("FAIL call_pc got=%h/%b exp=%h/0", pc, ras_empty, 32'h400); end
    ret = 1; jump_add = 32'hBAD0; #1;
    n_checks++; if (pc_4 !== 32'h14) begin n_fail++; $display("FAIL ret_pc4 got=%h exp=%h", pc_4, 32'h14); end
    step(); ret = 0;
    n_checks++; if (pc !== 32'h14 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL ret_pc got=%h/%b exp=%h/1", pc, ras_empty, 32'h14); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104};
    do_flush(32'h0);
    do_call(32'h100); do_call(32'h200); do_call(32'h300); do_call(32'h400);
    n_checks++; if (ras_full !== 1'b1) begin n_fail++; $display("FAIL full4 got=%b exp=1", ras_full); end
    do_call(32'h500);
    n_checks++; if (ras_full !== 1'b1 || pc !== 32'h500) begin
      n_fail++; $display("FAIL full5 got=%b/%h exp=1/%h", ras_full, pc, 32'h500); end
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); ret = 1; jump_add = 32'hDEAD0; step();
      n_checks++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ret%0d_pc got=%h exp=%h", i, pc, exp_ret[i]); end
    end
    n_checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_underflow !== 1'b0) begin
      n_fail++; $display("FAIL drained_flags got=%b%b%b exp=100", ras_empty, ras_full, ras_underflow); end
    step();
    n_checks++; if (pc !== 32'hDEAD0 || ras_underflow !== 1'b1) begin
      n_fail++; $display("FAIL underflow got=%h/%b exp=%h/1", pc, ras_underflow, 32'hDEAD0); end
    ret = 0; step();
    n_checks++; if (pc !== 32'hDEAD4 || ras_underflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_pulse got=%h/%b exp=%h/0", pc, ras_underflow, 32'hDEAD4); end
    ret = 1; stall = 1; step(); idle_inputs();
    n_checks++; if (pc !== 32'hDEAD4 || ras_underflow !== 1'b0) begin
      n_fail++; $display("FAIL stall_ret got=%h/%b exp=%h/0", pc, ras_underflow, 32'hDEAD4); end
  endtask

  task automatic test_indirect_call();
    do_flush(32'h4C);
    do_call(32'h60);
    call = 1; ret = 1; jump_add = 32'h777; #1;
    n_checks++; if (pc_4 !== 32'h50) begin n_fail++; $display("FAIL icall_pc4 got=%h exp=%h", pc_4, 32'h50); end
    step(); idle_inputs();
    n_checks++; if (pc !== 32'h50 || ras_empty !== 1'b0) begin
      n_fail++; $display("FAIL icall_pc got=%h/%b exp=%h/0", pc, ras_empty, 32'h50); end
    ret = 1; #1;
    n_checks++; if (pc_4 !== 32'h64) begin n_fail++; $display("FAIL icall_top got=%h exp=%h", pc_4, 32'h64); end
    step(); ret = 0;
    n_checks++; if (pc !== 32'h64 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL icall_count got=%h/%b exp=%h/1", pc, ras_empty, 32'h64); end
  endtask

  task automatic test_wrap_flush();
    do_flush(32'h0);
    do_call(32'h1000); do_call(32'h2000); do_call(32'hFFFF_FFFC);
    step();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
    n_checks++; if (ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      n_fail++; $display("FAIL count3_flags got=%b%b exp=00", ras_empty, ras_full); end
    do_flush(32'h300);
    n_checks++; if (pc !== 32'h300 || ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL flush_clear got=%h/%b exp=%h/1", pc, ras_empty, 32'h300); end
  endtask

  task automatic test_reset_priority();
    do_call(32'h900);
    idle_inputs(); reset = 1; stall = 1; flush = 1; flush_add = 32'h80; step(); idle_inputs();
    n_checks++; if (pc !== 32'h0 || ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_prio got=%h/%b/%b exp=%h/1/0", pc, ras_empty, ras_underflow, 32'h0); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_branch_stall_flush();
    test_call_ret();
    test_ras_overflow();
    test_indirect_call();
    test_wrap_flush();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Next-generation program-counter block for the fetch stage. It combines the PC register with next-PC selection and adds features the plain PC adder lacks:
- parametrised address width and increment
- pipeline stall hold
- high-priority flush/exception redirect
- a small circular return-address stack (RAS) for call/return prediction

It sits at the front of fetch and drives the instruction-memory address.

Parameters:
WIDTH, 32, address width of pc and all target buses
INC, 4, sequential increment added to pc
RESET_VECTOR, 32'h0000_0000, pc value loaded on reset
RAS_DEPTH, 4, number of return-stack entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
stall  input  1  hold pc and RAS this cycle (flush overrides)
jump  input  2  00 sequential, 01/11 jump_add, 10 jump_forward_add
jump_add  input  WIDTH  absolute/register jump target
jump_forward_add  input  WIDTH  pc-relative branch target
call  input  1  current transfer is a call; push pc+INC
ret  input  1  current transfer is a return; pop RAS for target
flush  input  1  redirect to flush_add; clears RAS
flush_add  input  WIDTH  exception/mispredict redirect address
pc  output  WIDTH  registered current PC
pc_4  output  WIDTH  combinational next PC (selected target)
ras_empty  output  1  RAS count == 0
ras_full  output  1  RAS count == RAS_DEPTH
ras_underflow  output  1  registered one-cycle pulse: ret issued with empty RAS

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). It has priority over all inputs.
- Reset values: pc=RESET_VECTOR, RAS count=0, RAS pointer=0, ras_underflow=0. After reset, ras_empty=1 and ras_full=0.
- Next-PC priority for pc_4, combinational, highest first:
  1. flush: flush_add.
  2. ret: RAS top if non-empty, else jump_add.
  3. jump 01/11: jump_add.
  4. jump 10: jump_forward_add.
  5. Otherwise: pc+INC.
- Arithmetic: pc+INC is modulo 2^WIDTH, so wrap from all-ones to 0 is legal and silent.
- Register update at each edge, when not in reset:
  - flush=1: pc<=flush_add; RAS count<=0, pointer<=0. Overrides stall, ignores call/ret.
  - else stall=1: pc, RAS and ras_underflow hold. ras_underflow is forced to 0 while stalled.
  - else: pc<=pc_4; RAS updated per the rules below.
- RAS push (call=1, ret=0): write pc+INC at pointer, pointer<=pointer+1 mod RAS_DEPTH, count<=min(count+1, RAS_DEPTH).
- RAS full on push: the oldest entry is overwritten by the pointer wrap. count saturates and ras_full stays 1. No error flag.
- RAS pop (ret=1, call=0), non-empty: target = entry[pointer-1]; pointer decrements mod RAS_DEPTH; count decrements.
- RAS pop when empty: target = jump_add; RAS unchanged; ras_underflow<=1 for exactly one cycle.
- call=1 and ret=1 together (indirect call): target = popped top, or jump_add if empty with underflow pulse. pc+INC is then written into that same top slot. Net effect: replace top; count unchanged if non-empty, else count<=1.
- call or ret with jump=00 is legal: RAS ops still occur, and ret still redirects.
- Latency: a redirect presented in cycle N appears on pc at cycle N+1. pc_4 is valid combinationally in cycle N.
- Reset asserted mid-stall or mid-flush: reset wins on that edge.

Decomposition:
- Shared package pc_pkg:
  - jump encodings JMP_SEQ=2'b00, JMP_ABS=2'b01, JMP_FWD=2'b10, JMP_ABS2=2'b11
  - default RESET_VECTOR and INC constants
- One natural sub-module: return_stack (WIDTH, RAS_DEPTH). Ports: clk, reset, clear, push, pop, push_data, top, empty, full. Storage, pointer and count live there.
- pc_unit holds the pc register, next-PC mux and underflow flag.

Test Plan:
- Reset then 3 idle cycles, RESET_VECTOR=0, INC=4 -> pc=0,4,8,12; ras_empty=1.
- At pc=0x100, jump=10, jump_forward_add=0x200 -> next pc=0x200. Then stall=1 for 2 cycles -> pc stays 0x200. Then flush=1 with stall=1, flush_add=0x80 -> pc=0x80.
- At pc=0x10, call with jump=01, jump_add=0x400 -> pc=0x400, RAS top=0x14. Then ret -> pc=0x14, ras_empty=1.
- RAS_DEPTH=4: five calls from pcs 0x0,0x100,0x200,0x300,0x400 -> ras_full=1. Four rets return 0x404,0x304,0x204,0x104; a fifth ret returns jump_add with ras_underflow pulse.
- With RAS top=0x50, call=1 and ret=1 at pc=0x60 -> pc=0x50, top=0x64, count unchanged.
- At pc=0xFFFF_FFFC with jump=00 -> pc wraps to 0x0000_0000; then flush with count=3 -> ras_empty=1.
